ov7670_sccb_cfg: RTL and testbench
==================================

# ov7670_sccb_cfg

Configuration sequencer for the OV7670 camera, sitting beside the pixel-capture path. It walks a synchronous register table and issues one SCCB 3-phase write (ID 0x42, register address, data) per entry on SIOC/SIOD. It honours delay and end markers, then raises DONE so the capture and frame-buffer logic can be enabled only after the sensor is in RGB565 mode.

## Interface
- QUARTER_CYCLES, 62: CLK cycles per SCCB quarter-bit. 25 MHz / 62 / 4 gives about 100 kHz SIOC.
- DELAY_CYCLES, 25000: CLK cycles waited on a delay marker (1 ms at 25 MHz).
- AUTO_START, 1: 1 = start the sequence automatically after reset release.
- DEV_ID, 8'h42: SCCB write ID byte.
- CLK  in  1  system clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  level; begins or reruns the sequence when sampled high in IDLE or DONE.
- TBL_ADDR  out  8  table index.
- TBL_DATA  in  16  {reg[15:8], val[7:0]}; valid 1 cycle after TBL_ADDR (registered ROM).
- SIOC  out  1  SCCB clock.
- SIOD  out  1  SCCB data value.
- SIOD_OE  out  1  1 = drive SIOD. The top level tristates the pad when 0.
- BUSY  out  1  high from sequence start until DONE.
- DONE  out  1  sticky; table finished. Cleared only by START or reset.

## Operation
- States: IDLE, FETCH, WAIT, DECODE, START_C, BITS, STOP_C, GAP, DELAY, FIN.
- Reset values: SIOC=1, SIOD=1, SIOD_OE=1, TBL_ADDR=0, BUSY=0, DONE=0. The FSM resets to IDLE.
- Leaving reset:
  - AUTO_START=1: IDLE moves to FETCH on the first clock.
  - AUTO_START=0: IDLE waits for START.
- START in IDLE or FIN:
  - TBL_ADDR←0, DONE←0, BUSY←1, then FETCH.
  - START is ignored in every other state.
- Table fetch: FETCH drives TBL_ADDR, WAIT spends one cycle, DECODE samples TBL_DATA.
- DECODE actions:
  - 16'hFFFF: end marker → FIN.
  - 16'hFFF0: delay marker → DELAY. Wait DELAY_CYCLES, TBL_ADDR+1, then FETCH. No bus activity.
  - Any other value: latch reg/val → START_C.
- Transaction quarter sequence. Every quarter lasts QUARTER_CYCLES cycles.
  - START_C, 2 quarters: (SIOC=1, SIOD=0), then (SIOC=0, SIOD=0).
  - BITS, 27 bits × 4 quarters: DEV_ID, X, reg, X, val, X. Bytes go out MSB first.
  - Within each bit, SIOD updates at the start of Q0 and SIOC is 0,0,1,1 over Q0..Q3. SIOD therefore changes only while SIOC=0.
  - X bits (the 9th bit of each phase) hold SIOD_OE=0 for all four quarters. No acknowledge is checked.
  - STOP_C, 3 quarters: (SIOC=0, SIOD=0), (SIOC=1, SIOD=0), (SIOC=1, SIOD=1).
  - GAP, 4 quarters: SIOC=1, SIOD=1, bus idle.
  - After GAP: TBL_ADDR+1, then FETCH.
- Entry 255: if TBL_ADDR=255 and the entry is not an end marker, it is processed and the FSM then goes to FIN. TBL_ADDR never wraps to 0.
- FIN: DONE=1, BUSY=0, bus idle, TBL_ADDR holds its last value.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Timing
- Quarter counter: ceil(log2(QUARTER_CYCLES)) bits, counting 0..QUARTER_CYCLES-1.
- Bit counter: 0..26. Delay counter: wide enough for DELAY_CYCLES.
- One write entry takes 2+108+3+4 = 117 quarters, plus 3 cycles for FETCH/WAIT/DECODE.
- Between successive write entries, the time from the SIOD-falling start condition of one to the next is exactly 117×QUARTER_CYCLES+3 cycles.
- First SIOD fall after reset release with AUTO_START=1 and a write at entry 0: 4 cycles (IDLE, FETCH, WAIT, DECODE).
- A delay entry adds DELAY_CYCLES+3 cycles.
- DONE rises on the cycle after DECODE sees FFFF, or after the GAP of entry 255.
- RST_N low at any point forces the reset values on the same edge as the asynchronous assert. This aborts a transaction mid-bit; the sensor sees SIOC and SIOD both high.

## Test plan
- Reset and idle: AUTO_START=0, no START for 1000 cycles → SIOC=SIOD=SIOD_OE=1, BUSY=0, DONE=0, TBL_ADDR=0.
- Single write, QUARTER_CYCLES=4, table {16'h1204, 16'hFFFF}:
  - A bus monitor sampling SIOD on SIOC rising edges decodes 0x42, 0x12, 0x04.
  - SIOD_OE=0 in exactly 3 bit slots.
  - DONE rises 4+117×4+3 cycles after reset release; SIOD never changes while SIOC=1 except at START/STOP.
- Delay marker, table {16'hFFF0, 16'h1180, 16'hFFFF}, DELAY_CYCLES=100: first start condition comes ≥100 cycles after the DECODE of entry 0; the bytes decode to 0x42, 0x11, 0x80.
- START handling:
  - START pulsed mid-transaction → ignored, the byte stream is unchanged.
  - START after DONE → DONE clears, TBL_ADDR=0, and the sequence repeats identically.
- Reset mid-bit: RST_N low during bit 10 → SIOC=1, SIOD=1, SIOD_OE=1, BUSY=0 asynchronously. After release the sequence restarts from entry 0.
- No end marker: 256 entries of 16'h3A04 → exactly 256 transactions, then DONE=1 with TBL_ADDR=255 and no 257th start condition.

Source files
------------

// File: rtl/ov7670_sccb_cfg.sv
// OV7670 configuration sequencer: walks a registered register table and issues one
// 3-phase SCCB write per entry, honouring delay and end markers, then raises DONE.
module ov7670_sccb_cfg #(
  parameter int         QUARTER_CYCLES = 62,
  parameter int         DELAY_CYCLES   = 25000,
  parameter bit         AUTO_START     = 1'b1,
  parameter logic [7:0] DEV_ID         = 8'h42
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  output logic [7:0]  TBL_ADDR,
  input  logic [15:0] TBL_DATA,
  output logic        SIOC,
  output logic        SIOD,
  output logic        SIOD_OE,
  output logic        BUSY,
  output logic        DONE
);

  localparam int QW = (QUARTER_CYCLES > 1) ? $clog2(QUARTER_CYCLES) : 1;
  localparam int DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [QW-1:0] Q_LAST   = QW'(QUARTER_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST   = DW'(DELAY_CYCLES - 1);
  localparam logic [15:0]   END_MARK = 16'hFFFF;
  localparam logic [15:0]   DLY_MARK = 16'hFFF0;

  typedef enum logic [3:0] {
    ST_IDLE, ST_FETCH, ST_WAIT, ST_DECODE, ST_START_C,
    ST_BITS, ST_STOP_C, ST_GAP, ST_DELAY, ST_FIN
  } state_t;

  state_t        state_r;
  logic [QW-1:0] qcnt_r;
  logic [1:0]    qph_r;
  logic [4:0]    bit_r;
  logic [DW-1:0] dcnt_r;
  logic [26:0]   frame_r;
  logic          qend_s;

  // The 9th bit of each phase is the released don't-care slot.
  function automatic logic ack_slot(input logic [4:0] idx);
    return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
  endfunction

  assign qend_s = (qcnt_r == Q_LAST);

  // Sequencer FSM with all bus and status outputs registered.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r  <= ST_IDLE;
      qcnt_r   <= '0;
      qph_r    <= 2'd0;
      bit_r    <= 5'd0;
      dcnt_r   <= '0;
      frame_r  <= '0;
      TBL_ADDR <= 8'd0;
      SIOC     <= 1'b1;
      SIOD     <= 1'b1;
      SIOD_OE  <= 1'b1;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_FIN: begin
          if ((state_r == ST_IDLE && AUTO_START) || START) begin
            TBL_ADDR <= 8'd0;
            DONE     <= 1'b0;
            BUSY     <= 1'b1;
            state_r  <= ST_FETCH;
          end else begin
            state_r <= state_r;
          end
        end
        ST_FETCH: state_r <= ST_WAIT;
        ST_WAIT:  state_r <= ST_DECODE;
        ST_DECODE: begin
          if (TBL_DATA == END_MARK) begin
            state_r <= ST_FIN;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end else if (TBL_DATA == DLY_MARK) begin
            state_r <= ST_DELAY;
            dcnt_r  <= '0;
          end else begin
            frame_r <= {DEV_ID, 1'b1, TBL_DATA[15:8], 1'b1, TBL_DATA[7:0], 1'b1};
            qcnt_r  <= '0;
            qph_r   <= 2'd0;
            state_r <= ST_START_C;
            SIOC    <= 1'b1;
            SIOD    <= 1'b0;
            SIOD_OE <= 1'b1;
          end
        end
        ST_START_C: begin
          if (!qend_s) begin
            qcnt_r <= qcnt_r + 1'b1;
          end else begin
            qcnt_r <= '0;
            SIOC   <= 1'b0;
            if (qph_r == 2'd0) begin
              qph_r <= 2'd1;
              SIOD  <= 1'b0;
            end else begin
              qph_r   <= 2'd0;
              bit_r   <= 5'd0;
              state_r <= ST_BITS;
              SIOD    <= frame_r[26];
              SIOD_OE <= 1'b1;
            end
          end
        end
        ST_BITS: begin
          if (!qend_s) begin
            qcnt_r <= qcnt_r + 1'b1;
          end else begin
            qcnt_r <= '0;
            if (qph_r != 2'd3) begin
              // SIOC is low for Q0/Q1 and high for Q2/Q3 of every bit.
              qph_r <= qph_r + 2'd1;
              SIOC  <= (qph_r != 2'd0);
            end else if (bit_r == 5'd26) begin
              qph_r   <= 2'd0;
              state_r <= ST_STOP_C;
              SIOC    <= 1'b0;
              SIOD    <= 1'b0;
              SIOD_OE <= 1'b1;
            end else begin
              qph_r   <= 2'd0;
              bit_r   <= bit_r + 5'd1;
              frame_r <= {frame_r[25:0], 1'b0};
              SIOC    <= 1'b0;
              SIOD    <= frame_r[25];
              SIOD_OE <= !ack_slot(bit_r + 5'd1);
            end
          end
        end
        ST_STOP_C: begin
          if (!qend_s) begin
            qcnt_r <= qcnt_r + 1'b1;
          end else begin
            qcnt_r <= '0;
            SIOC   <= 1'b1;
            if (qph_r == 2'd0) begin
              qph_r <= 2'd1;
              SIOD  <= 1'b0;
            end else if (qph_r == 2'd1) begin
              qph_r <= 2'd2;
              SIOD  <= 1'b1;
            end else begin
              qph_r   <= 2'd0;
              state_r <= ST_GAP;
              SIOD    <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (!qend_s) begin
            qcnt_r <= qcnt_r + 1'b1;
          end else begin
            qcnt_r <= '0;
            if (qph_r != 2'd3) begin
              qph_r <= qph_r + 2'd1;
            end else begin
              qph_r <= 2'd0;
              // The last table slot finishes the run rather than wrapping.
              if (TBL_ADDR == 8'd255) begin
                state_r <= ST_FIN;
                BUSY    <= 1'b0;
                DONE    <= 1'b1;
              end else begin
                TBL_ADDR <= TBL_ADDR + 8'd1;
                state_r  <= ST_FETCH;
              end
            end
          end
        end
        ST_DELAY: begin
          if (dcnt_r != D_LAST) begin
            dcnt_r <= dcnt_r + 1'b1;
          end else if (TBL_ADDR == 8'd255) begin
            state_r <= ST_FIN;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
          end else begin
            TBL_ADDR <= TBL_ADDR + 8'd1;
            state_r  <= ST_FETCH;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_cfg.sv
// Bench for ov7670_sccb_cfg: a bus monitor decodes SIOC/SIOD and is compared
// with a table-walking reference model that predicts bytes and cycle timing.
module tb_ov7670_sccb_cfg;
  localparam int QA = 4, DA = 100, QB = 1, DB = 100;

  logic clk = 1'b0;
  int   cyc = 0;
  logic rst_a = 1'b0, start_a = 1'b0, rst_b = 1'b0, start_b = 1'b0;
  logic sioc_a, siod_a, oe_a, busy_a, done_a;
  logic sioc_b, siod_b, oe_b, busy_b, done_b;
  logic [7:0]  addr_a, addr_b;
  logic [15:0] tdata_a, tdata_b;
  logic [15:0] rom [2][256];
  int n_chk = 0, n_fail = 0;

  ov7670_sccb_cfg #(.QUARTER_CYCLES(QA), .DELAY_CYCLES(DA), .AUTO_START(1'b1), .DEV_ID(8'h42)) u_a (
    .CLK(clk), .RST_N(rst_a), .START(start_a), .TBL_ADDR(addr_a), .TBL_DATA(tdata_a),
    .SIOC(sioc_a), .SIOD(siod_a), .SIOD_OE(oe_a), .BUSY(busy_a), .DONE(done_a));
  ov7670_sccb_cfg #(.QUARTER_CYCLES(QB), .DELAY_CYCLES(DB), .AUTO_START(1'b0), .DEV_ID(8'h42)) u_b (
    .CLK(clk), .RST_N(rst_b), .START(start_b), .TBL_ADDR(addr_b), .TBL_DATA(tdata_b),
    .SIOC(sioc_b), .SIOD(siod_b), .SIOD_OE(oe_b), .BUSY(busy_b), .DONE(done_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    tdata_a <= rom[0][addr_a];
    tdata_b <= rom[1][addr_b];
  end

  // Bus monitor for instance A: start/stop conditions, bytes sampled on SIOC rise.
  logic p_sioc_a = 1'b1, p_siod_a = 1'b1, p_done_a = 1'b0;
  logic [7:0] acc_a = 8'd0;
  logic [7:0] got_bytes [$];
  int start_t [$];
  int n_stop = 0, n_x = 0, n_rise = 0, done_t = 0;
  always @(negedge clk) begin
    if (!rst_a) acc_a <= 8'd0;
    else if (p_sioc_a && sioc_a && p_siod_a && !siod_a) begin
      start_t.push_back(cyc);
      acc_a <= 8'd0;
    end else if (p_sioc_a && sioc_a && !p_siod_a && siod_a) n_stop <= n_stop + 1;
    else if (!p_sioc_a && sioc_a) begin
      n_rise <= n_rise + 1;
      if (oe_a) acc_a <= {acc_a[6:0], siod_a};
      else begin
        n_x <= n_x + 1;
        got_bytes.push_back(acc_a);
      end
    end
    if (done_a && !p_done_a) done_t <= cyc;
    p_sioc_a <= sioc_a;
    p_siod_a <= siod_a;
    p_done_a <= done_a;
  end

  // Lighter monitor for instance B: start conditions and DONE rise time.
  logic p_sioc_b = 1'b1, p_siod_b = 1'b1, p_done_b = 1'b0;
  int n_start_b = 0, done_t_b = 0;
  always @(negedge clk) begin
    if (rst_b && p_sioc_b && sioc_b && p_siod_b && !siod_b) n_start_b <= n_start_b + 1;
    if (done_b && !p_done_b) done_t_b <= cyc;
    p_sioc_b <= sioc_b;
    p_siod_b <= siod_b;
    p_done_b <= done_b;
  end

  logic [7:0] exp_bytes [$];
  int exp_starts [$];
  int exp_done, exp_addr;
  int c0, bb, sb, stb, xb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic mark();
    c0 = cyc; bb = got_bytes.size(); sb = start_t.size(); stb = n_stop; xb = n_x;
  endtask

  // Reference: walk the table entry by entry, accumulating cycles from the run's first edge.
  task automatic model(input int inst, input int q, input int d);
    int t;
    logic [15:0] w;
    exp_bytes.delete();
    exp_starts.delete();
    t = 1;
    exp_addr = 0;
    for (int e = 0; e < 256; e++) begin
      w = rom[inst][e];
      t = t + 3;
      exp_addr = e;
      if (w == 16'hFFFF) break;
      if (w == 16'hFFF0) t = t + d;
      else begin
        exp_starts.push_back(t);
        exp_bytes.push_back(8'h42);
        exp_bytes.push_back(w[15:8]);
        exp_bytes.push_back(w[7:0]);
        t = t + 117 * q;
      end
    end
    exp_done = t;
  endtask

  function automatic logic [15:0] rnd_wr();
    logic [7:0] r, v;
    r = 8'($urandom_range(254, 0));
    v = 8'($urandom());
    return {r, v};
  endfunction

  task automatic fill_a();
    for (int e = 0; e < 256; e++) rom[0][e] = 16'hFFFF;
  endtask

  task automatic verify(input string tag);
    bit seen;
    int n;
    seen = 1'b0;
    for (int k = 0; k < 20000 && !seen; k++) begin
      tick(1);
      seen = done_a;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " done_time"}, done_t - c0, exp_done);
    n = exp_starts.size();
    check({tag, " starts"}, start_t.size() - sb, n);
    check({tag, " stops"}, n_stop - stb, n);
    check({tag, " ack_slots"}, n_x - xb, 3 * n);
    check({tag, " nbytes"}, got_bytes.size() - bb, exp_bytes.size());
    for (int k = 0; k < exp_bytes.size(); k++)
      if (bb + k < got_bytes.size())
        check($sformatf("%s byte%0d", tag, k), 32'(got_bytes[bb + k]), 32'(exp_bytes[k]));
    for (int k = 0; k < n; k++)
      if (sb + k < start_t.size())
        check($sformatf("%s start%0d", tag, k), start_t[sb + k] - c0, exp_starts[k]);
    check({tag, " addr"}, 32'(addr_a), exp_addr);
    check({tag, " busy"}, 32'(busy_a), 32'd0);
    check({tag, " idle_bus"}, 32'({sioc_a, siod_a, oe_a}), 32'd7);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int e = 0; e < 256; e++) begin
      rom[0][e] = 16'hFFFF;
      rom[1][e] = 16'h3A04;
    end
    tick(3);
    check("rst sioc", 32'(sioc_a), 32'd1);
    check("rst siod", 32'(siod_a), 32'd1);
    check("rst oe", 32'(oe_a), 32'd1);
    check("rst busy", 32'(busy_a), 32'd0);
    check("rst done", 32'(done_a), 32'd0);
    check("rst addr", 32'(addr_a), 32'd0);

    // No START with auto start off: B must stay idle.
    rst_b = 1'b1;
    tick(1000);
    check("idle bus", 32'({sioc_b, siod_b, oe_b}), 32'd7);
    check("idle busy", 32'(busy_b), 32'd0);
    check("idle done", 32'(done_b), 32'd0);
    check("idle addr", 32'(addr_b), 32'd0);
    check("idle starts", n_start_b, 32'd0);

    rom[0][0] = 16'h1204;
    model(0, QA, DA);
    rst_a = 1'b1;
    mark();
    verify("wr1");

    rst_a = 1'b0;
    tick(2);
    fill_a();
    rom[0][0] = 16'hFFF0; rom[0][1] = 16'h1180;
    model(0, QA, DA);
    rst_a = 1'b1;
    mark();
    verify("dly");
    if (start_t.size() > sb) check("dly decode_to_start", 32'((start_t[sb] - c0 - 4) >= 100), 32'd1);

    // START pulsed mid-transaction must not disturb the stream.
    rst_a = 1'b0;
    tick(2);
    fill_a();
    rom[0][0] = rnd_wr(); rom[0][1] = 16'hFFF0; rom[0][2] = rnd_wr(); rom[0][3] = rnd_wr();
    model(0, QA, DA);
    rst_a = 1'b1;
    mark();
    for (int k = 0; k < 100 && start_t.size() == sb; k++) tick(1);
    tick(40);
    start_a = 1'b1;
    tick(3);
    start_a = 1'b0;
    verify("midstart");

    start_a = 1'b1;
    mark();
    tick(1);
    start_a = 1'b0;
    check("rerun done_clr", 32'(done_a), 32'd0);
    check("rerun busy", 32'(busy_a), 32'd1);
    check("rerun addr", 32'(addr_a), 32'd0);
    verify("rerun");

    // Asynchronous reset during bit 10 of the first write.
    rst_a = 1'b0;
    tick(2);
    fill_a();
    rom[0][0] = rnd_wr(); rom[0][1] = rnd_wr();
    model(0, QA, DA);
    rst_a = 1'b1;
    mark();
    for (int k = 0; k < 100 && start_t.size() == sb; k++) tick(1);
    c0 = n_rise;
    for (int k = 0; k < 500 && n_rise - c0 < 10; k++) tick(1);
    tick(3 * QA);
    check("midbit sioc_low", 32'(sioc_a), 32'd0);
    rst_a = 1'b0;
    #1;
    check("async bus", 32'({sioc_a, siod_a, oe_a}), 32'd7);
    check("async busy", 32'(busy_a), 32'd0);
    check("async addr", 32'(addr_a), 32'd0);
    tick(2);
    rst_a = 1'b1;
    mark();
    verify("after_rst");

    // Full table without an end marker on instance B.
    model(1, QB, DB);
    sb = n_start_b;
    start_b = 1'b1;
    c0 = cyc;
    tick(1);
    start_b = 1'b0;
    check("long busy", 32'(busy_b), 32'd1);
    check("long done_clr", 32'(done_b), 32'd0);
    for (int k = 0; k < 40000 && !done_b; k++) tick(1);
    check("long done", 32'(done_b), 32'd1);
    check("long done_time", done_t_b - c0, exp_done);
    check("long starts", n_start_b - sb, exp_starts.size());
    check("long addr", 32'(addr_b), exp_addr);
    tick(300);
    check("long no_extra", n_start_b - sb, 32'd256);
    check("long hold_done", 32'(done_b), 32'd1);
    check("long hold_busy", 32'(busy_b), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
